dmem_port_arbiter: RTL

Shares the single-port data memory between two requesters: store-buffer drain writes (retired stores) and execute-stage load reads. It replaces the always-on read / free-running write wiring around the data memory with a one-operation-per-cycle scheduler. Loads have priority by default, and a starvation counter and a store-buffer-full override guarantee forward progress for stores. Read data returns with fixed one-cycle latency, and in-flight load responses are squashed on misprediction.

---
 rtl/dmem_port_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Single-port data memory scheduler: one load read or one store-buffer write per cycle.
// Optional stall counters are compiled in with `define DMEM_ARB_PERF_EN.
module dmem_port_arbiter #(
  parameter int WORD_SIZE_P  = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int LD_TAG_WIDTH = 3,
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    sb_w_v_i,
  input  logic [WORD_SIZE_P-1:0]  sb_w_addr_i,
  input  logic [WORD_SIZE_P-1:0]  sb_w_data_i,
  input  logic                    sb_full_i,
  output logic                    sb_w_ready_o,
  input  logic                    ld_v_i,
  input  logic [WORD_SIZE_P-1:0]  ld_addr_i,
  input  logic [LD_TAG_WIDTH-1:0] ld_tag_i,
  output logic                    ld_ready_o,
  output logic                    ld_resp_v_o,
  output logic [LD_TAG_WIDTH-1:0] ld_resp_tag_o,
  output logic [WORD_SIZE_P-1:0]  ld_resp_data_o,
  input  logic                    mispredict_i,
  output logic                    mem_w_v_o,
  output logic [WORD_SIZE_P-1:0]  mem_w_addr_o,
  output logic [WORD_SIZE_P-1:0]  mem_w_data_o,
  output logic                    mem_r_v_o,
  output logic [WORD_SIZE_P-1:0]  mem_r_addr_o,
  input  logic [WORD_SIZE_P-1:0]  mem_r_data_i,
  output logic                    dbg_state_o,
  output logic [CNT_W-1:0]        dbg_starve_cnt_o
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]             perf_ld_stall_o,
  output logic [15:0]             perf_wr_stall_o
`endif
);

  // Handshake: a request is transferred in the cycle where its valid and the
  // matching ready are both high; valid must hold its payload until then, and
  // ready is a combinational grant that never waits on the next cycle.

  typedef enum logic {
    LD_PRI   = 1'b0,
    WR_BURST = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        starve_q, starve_d;
  logic                    resp_v_q;
  logic [LD_TAG_WIDTH-1:0] resp_tag_q;
  logic                    ld_req, forced, ld_grant, wr_grant;

  always_comb begin
    state_d  = state_q;
    ld_grant = 1'b0;
    wr_grant = 1'b0;
    ld_req   = ld_v_i & ~mispredict_i;
    forced   = sb_full_i | (starve_q == LIMIT);
    // Grants are suppressed while reset is asserted so outputs clear at once.
    if (reset_n_i) begin
      case (state_q)
        LD_PRI: begin
          if (ld_req && !(sb_w_v_i && forced)) begin
            ld_grant = 1'b1;
          end else if (sb_w_v_i) begin
            wr_grant = 1'b1;
            if (sb_full_i) state_d = WR_BURST;
          end
        end
        WR_BURST: begin
          wr_grant = sb_w_v_i;
          if (!sb_full_i || !sb_w_v_i) state_d = LD_PRI;
        end
        default: state_d = LD_PRI;
      endcase
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (!sb_w_v_i || wr_grant) begin
      starve_d = '0;
    end else if (starve_q != LIMIT) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q    <= LD_PRI;
      starve_q   <= '0;
      resp_v_q   <= 1'b0;
      resp_tag_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      resp_v_q <= ld_grant;
      if (ld_grant) resp_tag_q <= ld_tag_i;
    end
  end

  assign ld_ready_o   = ld_grant;
  assign sb_w_ready_o = wr_grant;
  assign mem_r_v_o    = ld_grant;
  assign mem_r_addr_o = ld_grant ? ld_addr_i : '0;
  assign mem_w_v_o    = wr_grant;
  assign mem_w_addr_o = wr_grant ? sb_w_addr_i : '0;
  assign mem_w_data_o = wr_grant ? sb_w_data_i : '0;

  // A flush in the response cycle kills the load granted the cycle before.
  assign ld_resp_v_o    = resp_v_q & ~mispredict_i;
  assign ld_resp_tag_o  = ld_resp_v_o ? resp_tag_q : '0;
  assign ld_resp_data_o = ld_resp_v_o ? mem_r_data_i : '0;

  assign dbg_state_o      = state_q;
  assign dbg_starve_cnt_o = starve_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_ld_q, perf_wr_q;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_ld_q <= '0;
      perf_wr_q <= '0;
    end else begin
      if (ld_v_i && !ld_grant && perf_ld_q != 16'hFFFF) perf_ld_q <= perf_ld_q + 16'd1;
      if (sb_w_v_i && !wr_grant && perf_wr_q != 16'hFFFF) perf_wr_q <= perf_wr_q + 16'd1;
    end
  end

  assign perf_ld_stall_o = perf_ld_q;
  assign perf_wr_stall_o = perf_wr_q;
`endif

endmodule
